// File: rtl/branch_hazard_sequencer_if.sv
// branch_hazard_sequencer_if: ID-stage hazard inputs and pipeline control outputs
interface branch_hazard_sequencer_if #(parameter int REG_BITS = 3);
  logic [REG_BITS-1:0] IFID_rs1, IFID_rs2, IDEX_rd, EXMEM_rd;
  logic IFID_useRs2, branchInstr, comparatorOut;
  logic IDEX_regWrite, IDEX_memRead, EXMEM_memRead;
  logic pcWrite, IFID_write, IFID_flush, IDEX_bubble, branchPcSrc, stallActive;
  modport master (
    output IFID_rs1, IFID_rs2, IFID_useRs2, branchInstr, comparatorOut,
           IDEX_rd, IDEX_regWrite, IDEX_memRead, EXMEM_rd, EXMEM_memRead,
    input  pcWrite, IFID_write, IFID_flush, IDEX_bubble, branchPcSrc, stallActive
  );
  modport slave (
    input  IFID_rs1, IFID_rs2, IFID_useRs2, branchInstr, comparatorOut,
           IDEX_rd, IDEX_regWrite, IDEX_memRead, EXMEM_rd, EXMEM_memRead,
    output pcWrite, IFID_write, IFID_flush, IDEX_bubble, branchPcSrc, stallActive
  );
endinterface

// File: rtl/branch_hazard_sequencer.sv
// branch_hazard_sequencer: load-use / branch-operand stall and branch redirect control
// Optional BRANCH_STATS_EN adds saturating taken/branch/stall counters.
module branch_hazard_sequencer #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 8
) (
  input  logic clk,
  input  logic reset_n,
  branch_hazard_sequencer_if.slave io
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_BITS-1:0] branchTakenCnt,
  output logic [CNT_BITS-1:0] branchCnt,
  output logic [CNT_BITS-1:0] stallCnt
`endif
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state_q, state_d;
  logic [1:0] left_q, left_d;
  logic m_ex, m_mem, stall, redirect, resolved;
  logic [1:0] n;
  if (REG_BITS < 1 || CNT_BITS < 1) begin : g_param_check
    $error("branch_hazard_sequencer: REG_BITS and CNT_BITS must be positive");
  end
  always_comb begin
    m_ex = (io.IDEX_rd != REG_BITS'(0)) &&
           (io.IFID_rs1 == io.IDEX_rd || (io.IFID_useRs2 && io.IFID_rs2 == io.IDEX_rd));
    m_mem = (io.EXMEM_rd != REG_BITS'(0)) &&
            (io.IFID_rs1 == io.EXMEM_rd || (io.IFID_useRs2 && io.IFID_rs2 == io.EXMEM_rd));
    n = io.branchInstr ?
          ((m_ex && io.IDEX_memRead) ? 2'd2 :
           ((m_ex && io.IDEX_regWrite) || (m_mem && io.EXMEM_memRead)) ? 2'd1 : 2'd0) :
          (m_ex && io.IDEX_memRead) ? 2'd1 : 2'd0;
    stall = state_q == STALL || n != 2'd0;
    resolved = state_q == RUN && n == 2'd0 && io.branchInstr;
    redirect = resolved && io.comparatorOut;
    state_d = state_q;
    left_d = left_q;
    if (state_q == RUN) begin
      state_d = n == 2'd2 ? STALL : RUN;
      left_d = n == 2'd2 ? 2'd1 : 2'd0;
    end else begin
      left_d = left_q == 2'd0 ? 2'd0 : left_q - 2'd1;
      state_d = left_q <= 2'd1 ? RUN : STALL;
    end
  end
  // While reset is held the pipeline must free-run regardless of hazard inputs.
  assign io.pcWrite     = !reset_n || !stall;
  assign io.IFID_write  = !reset_n || !stall;
  assign io.IDEX_bubble = reset_n && stall;
  assign io.IFID_flush  = reset_n && redirect;
  assign io.branchPcSrc = reset_n && redirect;
  assign io.stallActive = state_q == STALL;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RUN;
      left_q <= 2'd0;
    end else begin
      state_q <= state_d;
      left_q <= left_d;
    end
`ifdef BRANCH_STATS_EN
  logic [CNT_BITS-1:0] taken_q, taken_d, br_q, br_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    taken_d = taken_q + CNT_BITS'(io.IFID_flush && !(&taken_q));
    br_d = br_q + CNT_BITS'(resolved && !(&br_q));
    stall_cnt_d = stall_cnt_q + CNT_BITS'(io.IDEX_bubble && !(&stall_cnt_q));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      taken_q <= '0;
      br_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_q <= taken_d;
      br_q <= br_d;
      stall_cnt_q <= stall_cnt_d;
    end
  assign branchTakenCnt = taken_q;
  assign branchCnt = br_q;
  assign stallCnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// tb_branch_hazard_sequencer: directed vectors plus a rule-level model checked every cycle
module tb_branch_hazard_sequencer;
  localparam int CMAX = 255;
  logic clk = 1'b0;
  logic reset_n;
  int total = 0, bad = 0;
  int pend = 0, tk = 0, bc = 0, sc = 0;
  branch_hazard_sequencer_if #(.REG_BITS(3)) bus ();
`ifdef BRANCH_STATS_EN
  logic [7:0] branchTakenCnt, branchCnt, stallCnt;
`endif
  branch_hazard_sequencer #(.REG_BITS(3), .CNT_BITS(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(bus)
`ifdef BRANCH_STATS_EN
    ,
    .branchTakenCnt(branchTakenCnt),
    .branchCnt(branchCnt),
    .stallCnt(stallCnt)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.pcWrite, bus.IFID_write, bus.IFID_flush, bus.IDEX_bubble, bus.branchPcSrc, bus.stallActive};
  endfunction

  function automatic bit hit(input logic [2:0] rd);
    return rd != 3'd0 && (bus.IFID_rs1 == rd || (bus.IFID_useRs2 && bus.IFID_rs2 == rd));
  endfunction

  function automatic int need();
    int n = 0;
    if (bus.branchInstr) begin
      if (hit(bus.IDEX_rd) && bus.IDEX_memRead) n = 2;
      if (hit(bus.IDEX_rd) && bus.IDEX_regWrite && !bus.IDEX_memRead && n < 1) n = 1;
      if (hit(bus.EXMEM_rd) && bus.EXMEM_memRead && n < 1) n = 1;
    end else if (hit(bus.IDEX_rd) && bus.IDEX_memRead) n = 1;
    return n;
  endfunction

  function automatic logic [5:0] model_outs();
    logic tkn;
    if (!reset_n) return 6'b110000;
    if (pend > 0) return 6'b000101;
    if (need() > 0) return 6'b000100;
    tkn = bus.branchInstr && bus.comparatorOut;
    return {2'b11, tkn, 1'b0, tkn, 1'b0};
  endfunction

  function automatic int sat(input int v);
    return v > CMAX ? CMAX : v;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic set(input bit br, cmp, input int rs1, rs2, input bit u2,
                     input int exrd, input bit ew, em, input int mrd, input bit mm);
    bus.branchInstr = br;
    bus.comparatorOut = cmp;
    bus.IFID_rs1 = 3'(rs1);
    bus.IFID_rs2 = 3'(rs2);
    bus.IFID_useRs2 = u2;
    bus.IDEX_rd = 3'(exrd);
    bus.IDEX_regWrite = ew;
    bus.IDEX_memRead = em;
    bus.EXMEM_rd = 3'(mrd);
    bus.EXMEM_memRead = mm;
  endtask

  task automatic cyc(input bit br, cmp, input int rs1, rs2, input bit u2,
                     input int exrd, input bit ew, em, input int mrd, input bit mm);
    @(posedge clk);
    #1;
    set(br, cmp, rs1, rs2, u2, exrd, ew, em, mrd, mm);
  endtask

  task automatic idle();
    cyc(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string nm, input logic [5:0] e);
    @(negedge clk);
    #1;
    check(nm, int'(outs()), int'(e));
  endtask

  initial begin
    logic [5:0] e;
    int n;
    forever begin
      @(negedge clk);
      e = model_outs();
      check("outs", int'(outs()), int'(e));
`ifdef BRANCH_STATS_EN
      check("taken_cnt", int'(branchTakenCnt), tk);
      check("branch_cnt", int'(branchCnt), bc);
      check("stall_cnt", int'(stallCnt), sc);
`endif
      if (!reset_n) begin
        pend = 0; tk = 0; bc = 0; sc = 0;
      end else begin
        n = need();
        tk = sat(tk + int'(e[3]));
        sc = sat(sc + int'(e[2]));
        bc = sat(bc + int'(pend == 0 && n == 0 && bus.branchInstr));
        pend = pend > 0 ? pend - 1 : (n == 2 ? 1 : 0);
      end
    end
  end

  initial begin
    int s0;
    reset_n = 1'b0;
    set(1, 1, 3, 0, 0, 3, 1, 1, 0, 0);
    lit("reset_gate", 6'b110000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    lit("idle", 6'b110000);
    // taken branch, no dependency: one flushed slot, no stall
    cyc(1, 1, 1, 2, 1, 4, 1, 0, 0, 0); lit("br_taken", 6'b111010);
    idle(); lit("after_taken", 6'b110000);
    // load -> branch: two bubbles, taken result during the stall ignored
    cyc(1, 1, 3, 0, 0, 3, 1, 1, 0, 0); lit("ld_br_1", 6'b000100);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 3, 1); lit("ld_br_2", 6'b000101);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); lit("ld_br_res", 6'b111010);
    // ALU -> branch through rs2: one bubble, then not-taken resolves
    cyc(1, 0, 2, 6, 1, 6, 1, 0, 0, 0); lit("alu_br_1", 6'b000100);
    cyc(1, 0, 2, 6, 1, 0, 0, 0, 6, 0); lit("alu_br_res", 6'b110000);
    // load -> ALU via rs2
    cyc(0, 0, 1, 5, 1, 5, 1, 1, 0, 0); lit("ld_alu_1", 6'b000100);
    cyc(0, 0, 1, 5, 1, 0, 0, 0, 5, 1); lit("ld_alu_adv", 6'b110000);
    cyc(0, 0, 1, 5, 0, 5, 1, 1, 0, 0); lit("ld_alu_no_rs2", 6'b110000);
    // r0 never matches
    cyc(1, 0, 0, 0, 1, 0, 1, 1, 0, 1); lit("r0_exempt", 6'b110000);
    // load in MEM -> branch: one bubble
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 7, 1); lit("mem_ld_br", 6'b000100);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); lit("mem_ld_res", 6'b111010);
    idle(); lit("idle2", 6'b110000);
`ifdef BRANCH_STATS_EN
    s0 = sc;
    cyc(1, 0, 3, 0, 0, 3, 1, 1, 0, 0);
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 3, 1);
    cyc(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    check("stall_plus2", int'(stallCnt), s0 + 2);
    for (int i = 0; i < 300; i++) cyc(1, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    #1;
    check("taken_sat", int'(branchTakenCnt), 255);
`else
    s0 = 0;
`endif
    // reset asserted mid-STALL
    cyc(1, 1, 3, 0, 0, 3, 1, 1, 0, 0); lit("rst_stall_1", 6'b000100);
    cyc(1, 1, 3, 0, 0, 3, 1, 1, 0, 0); lit("rst_stall_2", 6'b000101);
    reset_n = 1'b0;
    #1;
    check("rst_abort", int'(outs()), int'(6'b110000));
    cyc(1, 1, 3, 0, 0, 3, 1, 1, 0, 0); lit("rst_hold", 6'b110000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    lit("rst_release", 6'b110000);
    cyc(0, 0, 0, 5, 1, 5, 1, 1, 0, 0); lit("post_rst_haz", 6'b000100);
    idle(); lit("final_idle", 6'b110000);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
